paddle_y_controller: RTL and testbench

Sequencer that owns the 10-bit paddle Y coordinate for one Pong paddle and pushes it into the paddle-Y PIO output register over Avalon-MM. It debounces the up/down buttons and, once per video frame, computes the new clamped position. It then issues a single Avalon write to the PIO slave at address 0, only when the value changed. It sits between the frame timing generator, the button pins and the paddle PIO slave.

---
 rtl/paddle_y_controller_if.sv | 25 ++
 rtl/paddle_y_controller.sv | 143 ++++++++++++++
 tb/tb_paddle_y_controller.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/paddle_y_controller_if.sv
// Avalon-MM write-only bus between the paddle
// Y sequencer and the paddle-Y PIO slave.
interface paddle_y_controller_if;
  logic        av_waitrequest;
  logic [1:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [31:0] av_writedata;

  modport master (
    input  av_waitrequest,
    output av_address,
    output av_chipselect,
    output av_write_n,
    output av_writedata
  );

  modport slave (
    output av_waitrequest,
    input  av_address,
    input  av_chipselect,
    input  av_write_n,
    input  av_writedata
  );
endinterface

// File: rtl/paddle_y_controller.sv
// Paddle Y sequencer: debounced buttons, per-frame
// clamped move, single PIO write when Y changes.
module paddle_y_controller #(
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 400,
  parameter int Y_INIT          = 200,
  parameter int STEP            = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_tick,
  input  logic                   enable,
  input  logic                   btn_up_n,
  input  logic                   btn_down_n,
  input  logic                   clr_overrun,
  paddle_y_controller_if.master  av,
  output logic [9:0]             cur_y,
  output logic                   busy,
  output logic                   overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_INIT_WR,
    S_IDLE,
    S_UPDATE,
    S_WRITE
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [CW-1:0] r_cnt [2];
  logic [9:0]    r_cur_y;
  logic          r_overrun;
  logic          w_up;
  logic          w_dn;
  logic [10:0]   w_y11;
  logic [9:0]    w_next_y;
  logic          w_wr;
  logic          w_wr_q;
  logic          w_ovr_set;

  // Index 0 = up, 1 = down; levels are raw (1 = released)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_deb    <= 2'b11;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= {btn_down_n, btn_up_n};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_up  = ~r_deb[0];
  assign w_dn  = ~r_deb[1];
  assign w_y11 = {1'b0, r_cur_y};

  always_comb begin
    w_next_y = r_cur_y;
    unique case (1'b1)
      (w_up && !w_dn): begin
        if (w_y11 < 11'(Y_MIN + STEP))
          w_next_y = 10'(Y_MIN);
        else
          w_next_y = 10'(w_y11 - 11'(STEP));
      end
      (w_dn && !w_up): begin
        if (w_y11 > 11'(Y_MAX - STEP))
          w_next_y = 10'(Y_MAX);
        else
          w_next_y = 10'(w_y11 + 11'(STEP));
      end
      default: w_next_y = r_cur_y;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_wr       = 1'b0;
    unique case (r_state)
      S_INIT_WR: begin
        w_wr = 1'b1;
        if (!av.av_waitrequest) w_state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (frame_tick && enable) w_state_nx = S_UPDATE;
      end
      S_UPDATE: begin
        if (w_next_y == r_cur_y) w_state_nx = S_IDLE;
        else                     w_state_nx = S_WRITE;
      end
      S_WRITE: begin
        w_wr = 1'b1;
        if (!av.av_waitrequest) w_state_nx = S_IDLE;
      end
    endcase
  end

  assign w_ovr_set = frame_tick && enable && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_INIT_WR;
      r_cur_y   <= 10'(Y_INIT);
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_UPDATE) r_cur_y <= w_next_y;
      if (w_ovr_set)        r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  // Gate with reset so an asserted reset kills the strobe at once
  assign w_wr_q           = w_wr & reset_n;
  assign av.av_address    = 2'b00;
  assign av.av_chipselect = w_wr_q;
  assign av.av_write_n    = ~w_wr_q;
  assign av.av_writedata  = w_wr_q ? {22'b0, r_cur_y} : 32'b0;

  assign cur_y   = r_cur_y;
  assign busy    = (r_state != S_IDLE);
  assign overrun = r_overrun;

endmodule

// File: tb/tb_paddle_y_controller.sv
// Bench for paddle_y_controller: directed steps plus
// randomized button/enable episodes against a model.
module tb_paddle_y_controller;

  localparam int Y_MIN  = 0;
  localparam int Y_MAX  = 400;
  localparam int Y_INIT = 200;
  localparam int STEP   = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b1;
  logic       btn_up_n = 1'b1;
  logic       btn_down_n = 1'b1;
  logic       clr_overrun = 1'b0;
  logic [9:0] cur_y;
  logic       busy;
  logic       overrun;

  paddle_y_controller_if bus ();

  paddle_y_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .btn_up_n    (btn_up_n),
    .btn_down_n  (btn_down_n),
    .clr_overrun (clr_overrun),
    .av          (bus),
    .cur_y       (cur_y),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wd = '0;
  logic [1:0]  last_addr = '0;
  int          exp_y;

  // Accepted transfers: strobe low and slave not stalling
  always @(posedge clk) begin
    if (reset_n && bus.av_chipselect &&
        !bus.av_write_n && !bus.av_waitrequest) begin
      wr_cnt++;
      last_wd   = bus.av_writedata;
      last_addr = bus.av_address;
    end
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int model_step(int y, bit up, bit dn);
    if (up && !dn)
      return (y - STEP < Y_MIN) ? Y_MIN : y - STEP;
    if (dn && !up)
      return (y + STEP > Y_MAX) ? Y_MAX : y + STEP;
    return y;
  endfunction

  task automatic set_btn(bit up_n, bit dn_n);
    @(negedge clk);
    btn_up_n   = up_n;
    btn_down_n = dn_n;
    repeat (24) @(negedge clk);
  endtask

  // One tick with buttons long stable; model says what happens
  task automatic tick_check(string tag);
    int base;
    int nxt;
    base = wr_cnt;
    nxt  = enable ? model_step(exp_y, !btn_up_n, !btn_down_n)
                  : exp_y;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_nwr"}, wr_cnt - base, (nxt != exp_y) ? 1 : 0);
    if (nxt != exp_y) begin
      chk({tag, "_wd"}, last_wd, nxt);
      chk({tag, "_addr"}, last_addr, 0);
    end
    chk({tag, "_y"}, cur_y, nxt);
    chk({tag, "_busy"}, busy, 0);
    exp_y = nxt;
  endtask

  initial begin
    int base;
    int nxt;
    bus.av_waitrequest = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cs", bus.av_chipselect, 0);
    chk("rst_wn", bus.av_write_n, 1);
    chk("rst_wd", bus.av_writedata, 0);
    chk("rst_addr", bus.av_address, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_y", cur_y, Y_INIT);

    reset_n = 1'b1;
    #1;
    chk("init_cs", bus.av_chipselect, 1);
    chk("init_wn", bus.av_write_n, 0);
    chk("init_wd", bus.av_writedata, Y_INIT);
    chk("init_busy", busy, 1);
    @(negedge clk);
    chk("init_nwr", wr_cnt, 1);
    chk("init_idle", busy, 0);
    chk("init_cs_off", bus.av_chipselect, 0);
    chk("init_y", cur_y, Y_INIT);
    exp_y = Y_INIT;

    // Short press: not yet debounced when the tick lands
    @(negedge clk);
    btn_up_n = 1'b0;
    repeat (9) @(negedge clk);
    base = wr_cnt;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    btn_up_n = 1'b1;
    chk("short_nwr", wr_cnt - base, 0);
    chk("short_y", cur_y, Y_INIT);
    repeat (30) @(negedge clk);

    // 20-cycle press, exact tick-to-write latency
    btn_up_n = 1'b0;
    repeat (20) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("lat_upd_busy", busy, 1);
    chk("lat_upd_cs", bus.av_chipselect, 0);
    @(negedge clk);
    chk("lat_wr_cs", bus.av_chipselect, 1);
    chk("lat_wr_wn", bus.av_write_n, 0);
    chk("lat_wr_addr", bus.av_address, 0);
    chk("lat_wr_wd", bus.av_writedata, Y_INIT - STEP);
    @(negedge clk);
    chk("lat_idle", busy, 0);
    chk("lat_cs_off", bus.av_chipselect, 0);
    chk("lat_y", cur_y, Y_INIT - STEP);
    exp_y = Y_INIT - STEP;

    for (int i = 0; i < 50; i++) tick_check("up");
    chk("up_floor", cur_y, Y_MIN);

    set_btn(1'b1, 1'b0);
    for (int i = 0; i < 101; i++) tick_check("dn");
    chk("dn_ceil", cur_y, Y_MAX);

    set_btn(1'b0, 1'b0);
    tick_check("both");
    set_btn(1'b1, 1'b1);
    tick_check("none");

    for (int e = 0; e < 10; e++) begin
      set_btn(1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      enable = 1'($urandom_range(0, 1));
      repeat ($urandom_range(2, 6)) tick_check("rnd");
      chk("rnd_ovr", overrun, 0);
      enable = 1'b1;
    end

    // Stalled write with a tick landing inside it
    set_btn(exp_y > Y_INIT, exp_y <= Y_INIT);
    nxt  = model_step(exp_y, !btn_up_n, !btn_down_n);
    base = wr_cnt;
    @(negedge clk);
    bus.av_waitrequest = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_cs", bus.av_chipselect, 1);
      chk("stall_wn", bus.av_write_n, 0);
      chk("stall_wd", bus.av_writedata, nxt);
      if (k == 0) frame_tick = 1'b1;
      if (k == 1) frame_tick = 1'b0;
      if (k == 3) bus.av_waitrequest = 1'b0;
    end
    @(negedge clk);
    chk("stall_busy", busy, 0);
    chk("stall_ovr", overrun, 1);
    chk("stall_y", cur_y, nxt);
    repeat (3) @(negedge clk);
    chk("stall_nwr", wr_cnt - base, 1);
    chk("stall_last", last_wd, nxt);
    exp_y = nxt;
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Reset in the middle of a stalled write
    nxt = model_step(exp_y, !btn_up_n, !btn_down_n);
    @(negedge clk);
    bus.av_waitrequest = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    chk("mid_cs", bus.av_chipselect, 1);
    chk("mid_wd", bus.av_writedata, nxt);
    clr_overrun = 1'b1;
    frame_tick  = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    frame_tick  = 1'b0;
    chk("set_wins", overrun, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_cs", bus.av_chipselect, 0);
    chk("arst_wn", bus.av_write_n, 1);
    chk("arst_wd", bus.av_writedata, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_y", cur_y, Y_INIT);
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    bus.av_waitrequest = 1'b0;
    @(negedge clk);
    base = wr_cnt;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_nwr", wr_cnt - base, 1);
    chk("rel_wd", last_wd, Y_INIT);
    chk("rel_busy", busy, 0);
    chk("rel_y", cur_y, Y_INIT);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
